// File: rtl/vga_sync_monitor_if.sv
// Video stream as produced by the VGA source: 3-bit colour plus horizontal and
// vertical sync, one pixel per clock.
interface vga_sync_monitor_if;
  logic [2:0] rgb_in;
  logic       h_sync_i;
  logic       v_sync_i;

  modport master (output rgb_in, h_sync_i, v_sync_i);
  modport slave  (input  rgb_in, h_sync_i, v_sync_i);
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA checker: recovers pixel coordinates from the sync pulses,
// verifies line/frame timing, tracks lock and samples the colour at one probe point.
module vga_sync_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic                clk,
  input  logic                reset,
  vga_sync_monitor_if.slave   vid,
  input  logic [9:0]          probe_x,
  input  logic [9:0]          probe_y,
  input  logic                err_clr,
  output logic                locked,
  output logic                pix_valid,
  output logic [9:0]          pix_x,
  output logic [9:0]          pix_y,
  output logic [2:0]          pix_rgb,
  output logic [7:0]          frame_count,
  output logic [2:0]          probe_rgb,
  output logic                probe_valid,
  output logic                hsync_err,
  output logic                vsync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW    = 10'(H_SYNC - 1);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);
  localparam logic [9:0] H_LO    = 10'(H_START);
  localparam logic [9:0] H_HI    = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LO    = 10'(V_START);
  localparam logic [9:0] V_HI    = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic       ACTIVE  = 1'(SYNC_POL);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t     state;
  logic       hs_p1, vs_p1, hs_p2, vs_p2;
  logic [2:0] rgb_p1, rgb_p2;
  logic [9:0] hcnt, vcnt, vw;
  logic       vpend, h_seen, v_seen;
  logic       hs_on_p1, hs_on_p2, vs_on_p1, vs_on_p2;
  logic       hle, htrail, vle, vtrail;
  logic       h_err, v_err, any_err, hit;

  // Stage 1 / stage 2: pin capture, then one more delay for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_p1 <= ~ACTIVE;
      vs_p1 <= ~ACTIVE;
      hs_p2 <= ~ACTIVE;
      vs_p2 <= ~ACTIVE;
    end else begin
      hs_p1 <= vid.h_sync_i;
      vs_p1 <= vid.v_sync_i;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
    end
  end

  always_ff @(posedge clk) begin
    rgb_p1 <= vid.rgb_in;
    rgb_p2 <= rgb_p1;
  end

  always_comb begin
    hs_on_p1 = (hs_p1 == ACTIVE);
    hs_on_p2 = (hs_p2 == ACTIVE);
    vs_on_p1 = (vs_p1 == ACTIVE);
    vs_on_p2 = (vs_p2 == ACTIVE);
    hle      = hs_on_p1 && !hs_on_p2;
    htrail   = !hs_on_p1 && hs_on_p2;
    vle      = vs_on_p1 && !vs_on_p2;
    vtrail   = !vs_on_p1 && vs_on_p2;
    // hcnt tracks the stage-2 pixel, so at the trailing edge it holds width-1
    h_err    = h_seen && ((hle && (hcnt != H_LAST)) || (htrail && (hcnt != H_SW)));
    v_err    = v_seen && ((vle && (vcnt != V_LAST)) || (vtrail && (vw != V_SW)));
    any_err  = h_err || v_err;
  end

  // Stage 2 -> counters, lock state and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      hcnt        <= '0;
      vcnt        <= '0;
      vw          <= '0;
      vpend       <= 1'b0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      hsync_err   <= 1'b0;
      vsync_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      if (hle)                  hcnt <= '0;
      else if (hcnt != CNT_MAX) hcnt <= hcnt + 10'd1;

      // A VLE coinciding with an HLE lets that same HLE start the frame
      if (hle) begin
        if (vpend || vle)         vcnt <= '0;
        else if (vcnt != CNT_MAX) vcnt <= vcnt + 10'd1;
        vpend <= 1'b0;
      end else if (vle) begin
        vpend <= 1'b1;
      end

      if (vle)                                  vw <= hle ? 10'd1 : 10'd0;
      else if (hle && vs_on_p1 && vw != CNT_MAX) vw <= vw + 10'd1;

      if (any_err)  h_seen <= 1'b0;
      else if (hle) h_seen <= 1'b1;
      if (any_err)  v_seen <= 1'b0;
      else if (vle) v_seen <= 1'b1;

      if (h_err)        hsync_err <= 1'b1;
      else if (err_clr) hsync_err <= 1'b0;
      if (v_err)        vsync_err <= 1'b1;
      else if (err_clr) vsync_err <= 1'b0;

      if (any_err) begin
        state <= SEARCH;
      end else if (vle) begin
        case (state)
          SEARCH:  state <= ALIGN;
          ALIGN:   state <= LOCKED;
          LOCKED:  frame_count <= frame_count + 8'd1;
          default: state <= SEARCH;
        endcase
      end
    end
  end

  always_comb begin
    locked    = (state == LOCKED);
    pix_valid = locked && (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
    pix_x     = pix_valid ? (hcnt - H_LO) : '0;
    pix_y     = pix_valid ? (vcnt - V_LO) : '0;
    pix_rgb   = pix_valid ? rgb_p2 : '0;
    hit       = pix_valid && (pix_x == probe_x) && (pix_y == probe_y);
  end

  // Stage 3: probe capture
  always_ff @(posedge clk) begin
    if (reset) begin
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      probe_valid <= hit;
      if (hit) probe_rgb <= pix_rgb;
    end
  end

endmodule
